vote_logger_multi: RTL and testbench
====================================

Name: vote_logger_multi

Overview:
- Parametrised successor to the four-candidate vote counter: N candidates, configurable counter width, one-vote-per-ballot arming, saturating tallies.
- Adds edge-detected buttons, rejection of multi-press, running total, and a sequential winner scan in result mode.
- Sits between the synchronised/debounced button inputs and the display/result logic of the EVM.

Parameters:
- NUM_CAND, 4, number of candidates (2..16).
- CNT_W, 8, width of each per-candidate counter and of the total counter.
- IDX_W, $clog2(NUM_CAND), width of the winner index.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = voting, 1 = result.
- ballot_enable  in  1  officer pulse arming one ballot.
- cand_btn  in  NUM_CAND  level button inputs, already synchronised; bit i = candidate i.
- ballot_ready  out  1  high while a ballot is armed.
- vote_ack  out  1  one-cycle pulse when a vote is counted.
- vote_reject  out  1  one-cycle pulse on an illegal press (multi-press).
- counts  out  NUM_CAND*CNT_W  flattened tallies; candidate i at [i*CNT_W +: CNT_W].
- total  out  CNT_W  sum of counted votes, saturating.
- overflow  out  1  sticky; set when any counter or total saturates.
- winner  out  IDX_W  index of the highest tally.
- winner_valid  out  1  high when winner/tie reflect a completed scan.
- tie  out  1  high when the maximum tally is shared by more than one candidate.

Behaviour:
- Async reset (reset_n=0):
  - All counts, total, overflow, winner, tie, winner_valid, vote_ack, vote_reject and ballot_ready are 0.
  - Vote FSM goes to IDLE; scan FSM goes to S_OFF.
  - Button edge register is cleared to 0.
- Edge detect: btn_rise = cand_btn & ~cand_btn_q, where cand_btn_q is registered every cycle.
- Vote FSM, evaluated only while mode=0:
  - IDLE: ballot_enable=1 -> ARMED. ballot_ready rises the next cycle.
  - ARMED:
    - btn_rise one-hot -> increment that counter and total. vote_ack=1 in the same clock edge as the update. Go to RELEASE; ballot_ready drops.
    - btn_rise with more than one bit set -> vote_reject=1, no count, stay ARMED.
    - ballot_enable while ARMED is ignored.
  - RELEASE: wait until cand_btn == 0, then go to IDLE. A held button can never count twice.
- Presses in IDLE or RELEASE are ignored: no count, no reject.
- Saturation:
  - A counter at 2^CNT_W-1 holds its value; total likewise; overflow is set.
  - vote_ack still pulses, because the ballot is consumed.
- Mode transitions:
  - mode=1 in any vote state forces IDLE next cycle. An armed ballot is cancelled with no ack.
  - Counts are never cleared by a mode change, only by reset.
- Scan FSM:
  - S_OFF: on mode 0->1 transition, clear winner_valid, then go to S_SCAN with idx=0, best=counts[0], best_idx=0, tie=0.
  - S_SCAN: one candidate per cycle, idx=1..NUM_CAND-1.
    - count > best -> best=count, best_idx=idx, tie=0.
    - count == best -> tie=1.
  - After the last index -> S_DONE: winner=best_idx, winner_valid=1. Latency from mode rise to winner_valid is NUM_CAND cycles.
  - mode=0 in any scan state -> S_OFF and winner_valid=0. A partial scan is discarded.
- Tie-breaking: winner holds the lowest index among equal maxima. All-zero tallies give winner=0 and tie=1.
- Registered outputs: counts, total, winner and tie are registered. vote_ack and vote_reject are registered single-cycle pulses.

Test Plan:
- Reset, arm, press cand_btn=4'b0010 -> counts[1]=1, total=1, vote_ack for 1 cycle, ballot_ready 0 until the next arm.
- Hold cand_btn=4'b0001 for 10 cycles after one arm, release, press again without arming -> counts[0]=1 only, no further ack.
- Arm, press 4'b0101 simultaneously -> vote_reject pulse, counts unchanged, ballot_ready still 1; then press 4'b0100 -> counts[2]=1.
- CNT_W=3: cast 9 votes for candidate 3 -> counts[3]=7, total=7, overflow=1, 9 vote_acks.
- Tallies {2,5,5,1}, mode 0->1 -> winner_valid after 4 cycles, winner=1, tie=1. Tallies {0,0,3,1} -> winner=2, tie=0.
- Arm, then drive mode=1 before pressing, then assert reset_n=0 mid-scan -> ballot cancelled with no ack; all outputs 0 immediately (asynchronously) on reset.

Source files
------------

// File: rtl/vote_logger_multi.sv
// Multi-candidate vote logger: one vote per armed ballot, edge-detected buttons,
// saturating tallies, and a sequential winner scan in result mode.
module vote_logger_multi #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic                      ballot_enable,
  input  logic [NUM_CAND-1:0]       cand_btn,
  output logic                      ballot_ready,
  output logic                      vote_ack,
  output logic                      vote_reject,
  output logic [NUM_CAND*CNT_W-1:0] counts,
  output logic [CNT_W-1:0]          total,
  output logic                      overflow,
  output logic [IDX_W-1:0]          winner,
  output logic                      winner_valid,
  output logic                      tie
);

  typedef enum logic [1:0] {V_IDLE, V_ARMED, V_RELEASE} vstate_t;
  typedef enum logic [1:0] {S_OFF, S_SCAN, S_DONE} sstate_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CAND - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
    return (v != '0) && ((v & (v - NUM_CAND'(1))) == '0);
  endfunction

  vstate_t               vstate_q, vstate_d;
  sstate_t               sstate_q, sstate_d;
  logic [NUM_CAND-1:0]   cand_btn_q;
  logic                  mode_q;
  logic [CNT_W-1:0]      cnt_q [NUM_CAND];
  logic [CNT_W-1:0]      cnt_d [NUM_CAND];
  logic [CNT_W-1:0]      total_q, total_d;
  logic                  overflow_q, overflow_d;
  logic                  ack_q, ack_d;
  logic                  reject_q, reject_d;
  logic                  ready_q, ready_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      best_q, best_d;
  logic [IDX_W-1:0]      best_idx_q, best_idx_d;
  logic                  scan_tie_q, scan_tie_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic                  tie_q, tie_d;
  logic                  valid_q, valid_d;
  logic [NUM_CAND-1:0]   btn_rise;
  logic [CNT_W-1:0]      scan_cnt;

  assign btn_rise = cand_btn & ~cand_btn_q;
  assign scan_cnt = cnt_q[idx_q];

  always_comb begin
    vstate_d   = vstate_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    ack_d      = 1'b0;
    reject_d   = 1'b0;
    if (mode) begin
      // Result mode cancels any armed ballot without acknowledging it.
      vstate_d = V_IDLE;
    end else begin
      case (vstate_q)
        V_IDLE: if (ballot_enable) vstate_d = V_ARMED;
        V_ARMED: begin
          if (is_onehot(btn_rise)) begin
            for (int i = 0; i < NUM_CAND; i++) begin
              if (btn_rise[i]) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
                if (cnt_q[i] == CNT_MAX) overflow_d = 1'b1;
              end
            end
            total_d = sat_inc(total_q);
            if (total_q == CNT_MAX) overflow_d = 1'b1;
            ack_d    = 1'b1;
            vstate_d = V_RELEASE;
          end else if (btn_rise != '0) begin
            reject_d = 1'b1;
          end
        end
        V_RELEASE: if (cand_btn == '0) vstate_d = V_IDLE;
        default:   vstate_d = V_IDLE;
      endcase
    end
    ready_d = (vstate_d == V_ARMED);
  end

  always_comb begin
    sstate_d   = sstate_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    scan_tie_d = scan_tie_q;
    winner_d   = winner_q;
    tie_d      = tie_q;
    valid_d    = valid_q;
    if (!mode) begin
      sstate_d = S_OFF;
      valid_d  = 1'b0;
    end else begin
      case (sstate_q)
        S_OFF: begin
          if (!mode_q) begin
            valid_d    = 1'b0;
            sstate_d   = S_SCAN;
            idx_d      = IDX_W'(1);
            best_d     = cnt_q[0];
            best_idx_d = '0;
            scan_tie_d = 1'b0;
          end
        end
        S_SCAN: begin
          // Strict > keeps the lowest index among equal maxima.
          if (scan_cnt > best_q) begin
            best_d     = scan_cnt;
            best_idx_d = idx_q;
            scan_tie_d = 1'b0;
          end else if (scan_cnt == best_q) begin
            scan_tie_d = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            winner_d = best_idx_d;
            tie_d    = scan_tie_d;
            valid_d  = 1'b1;
            sstate_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DONE:  sstate_d = S_DONE;
        default: sstate_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vstate_q   <= V_IDLE;
      sstate_q   <= S_OFF;
      cand_btn_q <= '0;
      mode_q     <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
      reject_q   <= 1'b0;
      ready_q    <= 1'b0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      scan_tie_q <= 1'b0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      vstate_q   <= vstate_d;
      sstate_q   <= sstate_d;
      cand_btn_q <= cand_btn;
      mode_q     <= mode;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
      reject_q   <= reject_d;
      ready_q    <= ready_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      scan_tie_q <= scan_tie_d;
      winner_q   <= winner_d;
      tie_q      <= tie_d;
      valid_q    <= valid_d;
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_counts
    assign counts[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign ballot_ready = ready_q;
  assign vote_ack     = ack_q;
  assign vote_reject  = reject_q;
  assign total        = total_q;
  assign overflow     = overflow_q;
  assign winner       = winner_q;
  assign winner_valid = valid_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_vote_logger_multi.sv
// Directed bench for vote_logger_multi: an 8-bit instance plus a 3-bit instance
// sharing stimulus so saturation can be observed cheaply.
module tb_vote_logger_multi;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode = 1'b0;
  logic       ballot_enable = 1'b0;
  logic [3:0] cand_btn = 4'b0000;

  logic        a_ready, a_ack, a_rej, a_ovf, a_valid, a_tie;
  logic [31:0] a_counts;
  logic [7:0]  a_total;
  logic [1:0]  a_winner;
  logic        b_ready, b_ack, b_rej, b_ovf, b_valid, b_tie;
  logic [11:0] b_counts;
  logic [2:0]  b_total;
  logic [1:0]  b_winner;

  int checks = 0;
  int failures = 0;
  int ack_a = 0;
  int ack_b = 0;
  int rej_a = 0;
  int a0, b0, r0;

  vote_logger_multi #(.NUM_CAND(4), .CNT_W(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .mode(mode), .ballot_enable(ballot_enable),
    .cand_btn(cand_btn), .ballot_ready(a_ready), .vote_ack(a_ack), .vote_reject(a_rej),
    .counts(a_counts), .total(a_total), .overflow(a_ovf), .winner(a_winner),
    .winner_valid(a_valid), .tie(a_tie)
  );

  vote_logger_multi #(.NUM_CAND(4), .CNT_W(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .mode(mode), .ballot_enable(ballot_enable),
    .cand_btn(cand_btn), .ballot_ready(b_ready), .vote_ack(b_ack), .vote_reject(b_rej),
    .counts(b_counts), .total(b_total), .overflow(b_ovf), .winner(b_winner),
    .winner_valid(b_valid), .tie(b_tie)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (a_ack) ack_a++;
    if (b_ack) ack_b++;
    if (a_rej) rej_a++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cast(input logic [3:0] b);
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
    cand_btn = b;
    tick();
    cand_btn = 4'b0000;
    tick();
  endtask

  task automatic do_reset();
    mode = 1'b0;
    ballot_enable = 1'b0;
    cand_btn = 4'b0000;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] ca(input int i);
    return a_counts[i*8 +: 8];
  endfunction

  function automatic logic [2:0] cb(input int i);
    return b_counts[i*3 +: 3];
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_counts", a_counts, 0);
    chk("rst_total", a_total, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_ack_rej", {a_ack, a_rej}, 0);
    chk("rst_scan", {a_valid, a_tie, a_winner, a_ovf}, 0);
    reset_n = 1'b1;
    tick();

    // Single vote for candidate 1
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
    chk("t1_ready_armed", a_ready, 1);
    cand_btn = 4'b0010;
    tick();
    chk("t1_ack", a_ack, 1);
    chk("t1_cnt1", ca(1), 1);
    chk("t1_total", a_total, 1);
    chk("t1_ready_drop", a_ready, 0);
    cand_btn = 4'b0000;
    tick();
    chk("t1_ack_pulse", a_ack, 0);
    chk("t1_ready_idle", a_ready, 0);

    // Held button counts once; press without arming is ignored
    a0 = ack_a;
    r0 = rej_a;
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
    cand_btn = 4'b0001;
    repeat (10) tick();
    chk("t2_cnt0_held", ca(0), 1);
    cand_btn = 4'b0000;
    tick();
    cand_btn = 4'b0001;
    tick();
    cand_btn = 4'b0000;
    tick();
    tick();
    chk("t2_cnt0_unarmed", ca(0), 1);
    chk("t2_acks", ack_a - a0, 1);
    chk("t2_rejects", rej_a - r0, 0);
    chk("t2_total", a_total, 2);

    // Multi-press rejected, ballot stays armed
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
    cand_btn = 4'b0101;
    tick();
    chk("t3_reject", a_rej, 1);
    chk("t3_ready_kept", a_ready, 1);
    chk("t3_cnt2_none", ca(2), 0);
    chk("t3_cnt0_none", ca(0), 1);
    cand_btn = 4'b0000;
    tick();
    chk("t3_reject_pulse", a_rej, 0);
    cand_btn = 4'b0100;
    tick();
    chk("t3_ack", a_ack, 1);
    chk("t3_cnt2", ca(2), 1);
    chk("t3_total", a_total, 3);
    cand_btn = 4'b0000;
    tick();

    // Saturation on the 3-bit instance
    do_reset();
    b0 = ack_b;
    repeat (9) cast(4'b1000);
    tick();
    chk("t4_b_cnt3", cb(3), 7);
    chk("t4_b_total", b_total, 7);
    chk("t4_b_ovf", b_ovf, 1);
    chk("t4_b_acks", ack_b - b0, 9);
    chk("t4_a_cnt3", ca(3), 9);
    chk("t4_a_ovf", a_ovf, 0);

    // Winner scan with a tie at the maximum
    do_reset();
    repeat (2) cast(4'b0001);
    repeat (5) cast(4'b0010);
    repeat (5) cast(4'b0100);
    repeat (1) cast(4'b1000);
    mode = 1'b1;
    repeat (3) tick();
    chk("t5_valid_early", a_valid, 0);
    tick();
    chk("t5_valid", a_valid, 1);
    chk("t5_winner", a_winner, 1);
    chk("t5_tie", a_tie, 1);
    mode = 1'b0;
    tick();
    chk("t5_valid_clear", a_valid, 0);
    chk("t5_counts_kept", a_counts, 32'h01_05_05_02);

    // All-zero tallies
    do_reset();
    mode = 1'b1;
    repeat (4) tick();
    chk("t5z_valid", a_valid, 1);
    chk("t5z_winner", a_winner, 0);
    chk("t5z_tie", a_tie, 1);
    mode = 1'b0;
    tick();

    // Unique maximum
    do_reset();
    repeat (3) cast(4'b0100);
    repeat (1) cast(4'b1000);
    mode = 1'b1;
    repeat (4) tick();
    chk("t5b_valid", a_valid, 1);
    chk("t5b_winner", a_winner, 2);
    chk("t5b_tie", a_tie, 0);
    mode = 1'b0;
    tick();

    // Armed ballot cancelled by result mode, then async reset mid-scan
    a0 = ack_a;
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
    chk("t6_ready_armed", a_ready, 1);
    mode = 1'b1;
    tick();
    chk("t6_ready_cancel", a_ready, 0);
    cand_btn = 4'b0001;
    tick();
    cand_btn = 4'b0000;
    tick();
    chk("t6_no_ack", ack_a - a0, 0);
    chk("t6_cnt0", ca(0), 0);
    chk("t6_valid_midscan", a_valid, 0);
    chk("t6_winner_held", a_winner, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_counts", a_counts, 0);
    chk("t6_rst_total", a_total, 0);
    chk("t6_rst_winner", a_winner, 0);
    chk("t6_rst_flags", {a_valid, a_tie, a_ready, a_ack, a_rej, a_ovf}, 0);
    mode = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
